m_stage_mem_ctrl: RTL

Memory-stage access controller of the five-stage MIPS pipeline: the consumer of the E/M pipeline register outputs. It decodes the M-stage instruction, performs load/store alignment checks, drives a handshaked data-memory bus, and stalls the pipeline until the access completes. Its results (extended load data, exception info) feed the M/W register and the exception unit.

---
 rtl/mips_pkg.sv | 68 ++++++
 rtl/m_load_ext.sv | 29 ++
 rtl/m_stage_mem_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: memory opcodes, exception codes, M-stage FSM states
// and the store-lane encoding helpers.
package mips_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_DBE  = 5'd7;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StResp
    } mem_state_e;

    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] lane);
        logic res;
        res = 1'b0;
        case (op)
            OP_LW, OP_SW:          res = (lane != 2'b00);
            OP_LH, OP_LHU, OP_SH:  res = lane[0];
            default:               res = 1'b0;
        endcase
        return res;
    endfunction

    // Loads read the whole word; the extender picks the lane afterwards.
    function automatic logic [3:0] store_be(input logic [5:0] op, input logic [1:0] lane);
        logic [3:0] be;
        be = 4'b1111;
        case (op)
            OP_SH:   be = lane[1] ? 4'b1100 : 4'b0011;
            OP_SB:   be = 4'b0001 << lane;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_wdata(input logic [5:0] op, input logic [31:0] rt);
        logic [31:0] wd;
        wd = '0;
        case (op)
            OP_SW:   wd = rt;
            OP_SH:   wd = {2{rt[15:0]}};
            OP_SB:   wd = {4{rt[7:0]}};
            default: wd = '0;
        endcase
        return wd;
    endfunction

endpackage

// File: rtl/m_load_ext.sv
// Load-data extender: selects the addressed byte/half lane of the read word and
// sign- or zero-extends it according to the load opcode.
module m_load_ext
    import mips_pkg::*;
(
    input  logic [5:0]  op_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] dr_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[8*lane_i +: 8];
        half_sel = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        dr_o     = '0;
        case (op_i)
            OP_LW:   dr_o = rdata_i;
            OP_LB:   dr_o = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  dr_o = {24'h0, byte_sel};
            OP_LH:   dr_o = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  dr_o = {16'h0, half_sel};
            default: dr_o = '0;
        endcase
    end

endmodule

// File: rtl/m_stage_mem_ctrl.sv
// M-stage memory access controller: decodes loads/stores, checks alignment, runs the
// handshaked data bus with a timeout, and stalls the pipeline until the access is done.
module m_stage_mem_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_m,
    input  logic [31:0] ir_m,
    input  logic [31:0] pc_m,
    input  logic [31:0] ao_m,
    input  logic [31:0] rt_m,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        stall_m,
    output logic        done_m,
    output logic [31:0] dr_m,
    output logic        exc_m,
    output logic [4:0]  exc_code,
    output logic [31:0] exc_pc
);

    localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

    mem_state_e  state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [5:0]  op_q, op_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] pc_q, pc_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        done_q, done_d;
    logic [31:0] dr_q, dr_d;
    logic        exc_q, exc_d;
    logic [4:0]  code_q, code_d;
    logic [31:0] exc_pc_q, exc_pc_d;

    logic [5:0]  op;
    logic        mem_op;
    logic [31:0] ext_dr;
    logic        unused_ir;

    assign op        = ir_m[31:26];
    assign mem_op    = valid_m && (is_load(op) || is_store(op));
    assign unused_ir = ^ir_m[25:0];

    m_load_ext u_load_ext (
        .op_i    (op_q),
        .lane_i  (lane_q),
        .rdata_i (mem_rdata),
        .dr_o    (ext_dr)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        lane_d   = lane_q;
        pc_d     = pc_q;
        we_d     = we_q;
        be_d     = be_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        done_d   = 1'b0;
        dr_d     = '0;
        exc_d    = 1'b0;
        code_d   = '0;
        exc_pc_d = '0;
        stall_m  = 1'b0;

        case (state_q)
            StIdle: begin
                if (mem_op) begin
                    stall_m = 1'b1;
                    op_d    = op;
                    lane_d  = ao_m[1:0];
                    pc_d    = pc_m;
                    if (is_misaligned(op, ao_m[1:0])) begin
                        state_d  = StResp;
                        done_d   = 1'b1;
                        exc_d    = 1'b1;
                        code_d   = is_load(op) ? EXC_ADEL : EXC_ADES;
                        exc_pc_d = pc_m;
                    end else begin
                        state_d = StReq;
                        cnt_d   = '0;
                        we_d    = is_store(op);
                        be_d    = store_be(op, ao_m[1:0]);
                        addr_d  = {ao_m[31:2], 2'b00};
                        wdata_d = store_wdata(op, rt_m);
                    end
                end
            end
            StReq: begin
                stall_m = 1'b1;
                if (mem_ready || (cnt_q == CntW'(MAX_WAIT - 1))) begin
                    state_d = StResp;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    we_d    = 1'b0;
                    be_d    = '0;
                    addr_d  = '0;
                    wdata_d = '0;
                    // A completing access wins over the timeout in the same cycle.
                    if (mem_ready) begin
                        dr_d = is_load(op_q) ? ext_dr : '0;
                    end else begin
                        exc_d    = 1'b1;
                        code_d   = EXC_DBE;
                        exc_pc_d = pc_q;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (!reset) begin
            stall_m = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            op_q     <= '0;
            lane_q   <= '0;
            pc_q     <= '0;
            we_q     <= 1'b0;
            be_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            done_q   <= 1'b0;
            dr_q     <= '0;
            exc_q    <= 1'b0;
            code_q   <= '0;
            exc_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            lane_q   <= lane_d;
            pc_q     <= pc_d;
            we_q     <= we_d;
            be_q     <= be_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            done_q   <= done_d;
            dr_q     <= dr_d;
            exc_q    <= exc_d;
            code_q   <= code_d;
            exc_pc_q <= exc_pc_d;
        end
    end

    assign mem_req   = (state_q == StReq);
    assign mem_we    = we_q;
    assign mem_be    = be_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign done_m    = done_q;
    assign dr_m      = dr_q;
    assign exc_m     = exc_q;
    assign exc_code  = code_q;
    assign exc_pc    = exc_pc_q;

endmodule
